// File: rtl/mesi_isc_breq_arb_pkg.sv
// Shared definitions for the broadcast-request arbiter: CPU count,
// broadcast request type codes and the arbiter FSM state encoding.
package mesi_isc_breq_arb_pkg;

  localparam int CPU_COUNT    = 4;
  localparam int CPU_ID_WIDTH = 2;

  typedef logic [1:0] breq_type_t;

  localparam breq_type_t MESI_ISC_BREQ_TYPE_NOP = 2'd0;
  localparam breq_type_t MESI_ISC_BREQ_TYPE_WR  = 2'd1;
  localparam breq_type_t MESI_ISC_BREQ_TYPE_RD  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_PUSH = 2'd2
  } breq_state_e;

  function automatic logic [CPU_ID_WIDTH-1:0] rr_after(input logic [CPU_ID_WIDTH-1:0] g);
    return g + 1'b1;
  endfunction

endpackage

// File: rtl/mesi_isc_breq_arb_rr_arb4.sv
// 4-way round-robin priority select: the first requester found scanning
// upward (mod 4) from ptr wins. Purely combinational.
module mesi_isc_rr_arb4
  import mesi_isc_breq_arb_pkg::*;
(
  input  logic [CPU_COUNT-1:0]    req,
  input  logic [CPU_ID_WIDTH-1:0] ptr,
  output logic                    gnt_valid,
  output logic [CPU_ID_WIDTH-1:0] gnt_id
);

  always_comb begin : p_select
    logic [CPU_ID_WIDTH-1:0] idx;
    idx       = '0;
    gnt_valid = 1'b0;
    gnt_id    = ptr;
    // Scan farthest-first so the closest requester to ptr is written last.
    for (int i = CPU_COUNT - 1; i >= 0; i--) begin
      idx = ptr + CPU_ID_WIDTH'(i);
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx;
      end
    end
  end

endmodule

// File: rtl/mesi_isc_breq_arb.sv
// Broadcast request arbiter: pops one per-CPU request FIFO head in
// round-robin order and pushes it into the broadcast FIFO.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | pick a non-empty CPU, latch grant, advance rr pointer
// POP     | re-check grant still non-empty; strobe pop and capture head
// PUSH    | push captured entry when broadcast FIFO not full, else hold
module mesi_isc_breq_arb
  import mesi_isc_breq_arb_pkg::*;
#(
  parameter int BROAD_TYPE_WIDTH = 2,
  parameter int BROAD_ID_WIDTH   = 5,
  parameter int ADDR_WIDTH       = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [CPU_COUNT-1:0]              fifo_status_empty_array_i,
  input  logic [CPU_COUNT*BROAD_TYPE_WIDTH-1:0] breq_type_array_i,
  input  logic [CPU_COUNT*BROAD_ID_WIDTH-1:0]   breq_id_array_i,
  input  logic [CPU_COUNT*ADDR_WIDTH-1:0]       breq_addr_array_i,
  output logic [CPU_COUNT-1:0]              fifo_rd_array_o,
  input  logic                              broad_fifo_status_full_i,
  output logic                              broad_fifo_wr_o,
  output logic [BROAD_TYPE_WIDTH-1:0]       broad_type_o,
  output logic [CPU_ID_WIDTH-1:0]           broad_cpu_id_o,
  output logic [BROAD_ID_WIDTH-1:0]         broad_id_o,
  output logic [ADDR_WIDTH-1:0]             broad_addr_o
);

  breq_state_e               state_q, state_d;
  logic [CPU_ID_WIDTH-1:0]   rr_ptr_q;
  logic [CPU_ID_WIDTH-1:0]   gnt_q;
  logic                      arb_valid;
  logic [CPU_ID_WIDTH-1:0]   arb_id;
  logic [CPU_COUNT-1:0]      arb_req;

  logic [BROAD_TYPE_WIDTH-1:0] sel_type;
  logic [BROAD_ID_WIDTH-1:0]   sel_id;
  logic [ADDR_WIDTH-1:0]       sel_addr;
  logic                        sel_empty;
  logic                        sel_nop;

  logic [CPU_COUNT-1:0]      rd_d;
  logic                      wr_d;
  logic                      capture;
  logic                      grant_load;

  // A CPU whose pop strobe is still out has a stale head until the FIFO
  // updates, so it is kept out of the next selection.
  assign arb_req = ~fifo_status_empty_array_i & ~fifo_rd_array_o;

  mesi_isc_rr_arb4 u_rr_arb4 (
    .req       (arb_req),
    .ptr       (rr_ptr_q),
    .gnt_valid (arb_valid),
    .gnt_id    (arb_id)
  );

  assign sel_type  = breq_type_array_i[int'(gnt_q)*BROAD_TYPE_WIDTH +: BROAD_TYPE_WIDTH];
  assign sel_id    = breq_id_array_i[int'(gnt_q)*BROAD_ID_WIDTH +: BROAD_ID_WIDTH];
  assign sel_addr  = breq_addr_array_i[int'(gnt_q)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_empty = fifo_status_empty_array_i[gnt_q];
  assign sel_nop   = (sel_type == BROAD_TYPE_WIDTH'(MESI_ISC_BREQ_TYPE_NOP));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (arb_valid) state_d = ST_POP;
      ST_POP: begin
        if (sel_empty || sel_nop) state_d = ST_IDLE;
        else                      state_d = ST_PUSH;
      end
      ST_PUSH: if (!broad_fifo_status_full_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_d       = '0;
    wr_d       = 1'b0;
    capture    = 1'b0;
    grant_load = 1'b0;
    unique case (state_q)
      ST_IDLE: grant_load = arb_valid;
      ST_POP: begin
        if (!sel_empty) begin
          rd_d    = CPU_COUNT'(1) << gnt_q;
          capture = 1'b1;
        end
      end
      ST_PUSH: wr_d = !broad_fifo_status_full_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q        <= '0;
      gnt_q           <= '0;
      fifo_rd_array_o <= '0;
      broad_fifo_wr_o <= 1'b0;
      broad_type_o    <= '0;
      broad_cpu_id_o  <= '0;
      broad_id_o      <= '0;
      broad_addr_o    <= '0;
    end else begin
      fifo_rd_array_o <= rd_d;
      broad_fifo_wr_o <= wr_d;
      if (grant_load) begin
        gnt_q    <= arb_id;
        rr_ptr_q <= rr_after(arb_id);
      end
      // Entry fields only change on a pop, so they stay put across stalls.
      if (capture) begin
        broad_type_o   <= sel_type;
        broad_cpu_id_o <= gnt_q;
        broad_id_o     <= sel_id;
        broad_addr_o   <= sel_addr;
      end
    end
  end

endmodule
